// File: rtl/alu_sequencer.sv
// Control FSM for the BitBlaster 10-bit datapath: latches one instruction and sequences
// register/bus/ALU strobes over up to three steps. Optional illegal-op trap: CTRL_ILLEGAL_TRAP_EN.
module alu_sequencer #(
  parameter int DATA_W = 10,
  parameter int IMM_W  = 6
) (
  input  logic              CLKb,
  input  logic              RSTb,
  input  logic [DATA_W-1:0] INSTR,
  input  logic              EXEC,
  output logic              BUSY,
  output logic              DONE,
  output logic [3:0]        Rin,
  output logic [3:0]        Rout,
  output logic              EXT,
  output logic              IMMout,
  output logic [DATA_W-1:0] IMM,
  output logic              Ain,
  output logic              Gin,
  output logic              Gout,
  output logic [3:0]        FN,
  output logic              ERR
);

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} step_t;
  typedef enum logic [2:0] {C_LD, C_CP, C_UN, C_BIN, C_IMM, C_ILL} cls_t;

  typedef struct packed {
    logic       done;
    logic       err;
    logic [3:0] rin;
    logic [3:0] rout;
    logic       ext;
    logic       immout;
    logic       ain;
    logic       gin;
    logic       gout;
    logic [3:0] fn;
  } ctrl_t;

  step_t             step, step_nxt;
  logic [DATA_W-1:0] ir;
  logic [1:0]        mode, rx, ry;
  logic [3:0]        fn_ir;
  cls_t              cls;
  ctrl_t             c;

  assign mode  = ir[DATA_W-1 -: 2];
  assign rx    = ir[DATA_W-3 -: 2];
  assign ry    = ir[DATA_W-5 -: 2];
  assign fn_ir = ir[3:0];

  function automatic logic [3:0] oh(input logic [1:0] r);
    oh = 4'b0001 << r;
  endfunction

  always_comb begin
    cls = C_ILL;
    case (mode)
      2'b00: begin
        case (fn_ir)
          4'b0000:                   cls = C_LD;
          4'b0001:                   cls = C_CP;
          4'b0100, 4'b0101:          cls = C_UN;
          4'b0010, 4'b0011, 4'b0110, 4'b0111,
          4'b1000, 4'b1001, 4'b1010, 4'b1011: cls = C_BIN;
          default:                   cls = C_ILL;
        endcase
      end
      2'b10, 2'b11: cls = C_IMM;
      default:      cls = C_ILL;
    endcase
  end

  always_ff @(negedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      step <= S_IDLE;
      ir   <= '0;
    end else begin
      step <= step_nxt;
      if (step == S_IDLE && EXEC) ir <= INSTR;
    end
  end

  // Single-step classes (ld/cp/illegal) finish in T1; ALU classes run T1..T3.
  always_comb begin
    step_nxt = step;
    c        = '0;
    case (step)
      S_IDLE: if (EXEC) step_nxt = S_T1;
      S_T1: begin
        case (cls)
          C_LD: begin
            c.ext = 1'b1; c.rin = oh(rx); c.done = 1'b1;
            step_nxt = S_IDLE;
          end
          C_CP: begin
            c.rout = oh(ry); c.rin = oh(rx); c.done = 1'b1;
            step_nxt = S_IDLE;
          end
          C_UN: begin
            c.rout = oh(ry); c.ain = 1'b1;
            step_nxt = S_T2;
          end
          C_BIN, C_IMM: begin
            c.rout = oh(rx); c.ain = 1'b1;
            step_nxt = S_T2;
          end
          default: begin
            c.done = 1'b1; c.err = TRAP_EN;
            step_nxt = S_IDLE;
          end
        endcase
      end
      S_T2: begin
        c.gin = 1'b1;
        if (cls == C_IMM) begin
          c.immout = 1'b1;
          c.fn     = {3'b110, mode[0]};
        end else begin
          c.fn = fn_ir;
        end
        if (cls == C_BIN) c.rout = oh(ry);
        step_nxt = S_T3;
      end
      S_T3: begin
        c.gout = 1'b1; c.rin = oh(rx); c.done = 1'b1;
        step_nxt = S_IDLE;
      end
      default: step_nxt = S_IDLE;
    endcase
  end

  assign BUSY   = (step != S_IDLE);
  assign DONE   = c.done;
  assign ERR    = c.err;
  assign Rin    = c.rin;
  assign Rout   = c.rout;
  assign EXT    = c.ext;
  assign IMMout = c.immout;
  assign Ain    = c.ain;
  assign Gin    = c.gin;
  assign Gout   = c.gout;
  assign FN     = c.fn;
  // IMM is only meaningful while an addi/subi is in flight; held at 0 otherwise.
  assign IMM    = (BUSY && mode[1]) ? {{(DATA_W-IMM_W){1'b0}}, ir[IMM_W-1:0]} : '0;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: per-cycle expected strobe vectors queued at issue,
// popped and compared half a cycle after each state-changing negedge.
module tb_alu_sequencer;
  logic       CLKb = 1'b1;
  logic       RSTb;
  logic [9:0] INSTR;
  logic       EXEC;
  logic       BUSY, DONE, EXT, IMMout, Ain, Gin, Gout, ERR;
  logic [3:0] Rin, Rout, FN;
  logic [9:0] IMM;

  alu_sequencer #(.DATA_W(10), .IMM_W(6)) dut (
    .CLKb(CLKb), .RSTb(RSTb), .INSTR(INSTR), .EXEC(EXEC),
    .BUSY(BUSY), .DONE(DONE), .Rin(Rin), .Rout(Rout), .EXT(EXT),
    .IMMout(IMMout), .IMM(IMM), .Ain(Ain), .Gin(Gin), .Gout(Gout),
    .FN(FN), .ERR(ERR)
  );

  always #5 CLKb = ~CLKb;

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic       err, busy, done;
    logic [3:0] rin, rout;
    logic       ext, immout, ain, gin, gout;
    logic [3:0] fn;
    logic [9:0] imm;
  } ov_t;

  ov_t q[$];
  int  checks = 0;
  int  passes = 0;

  function automatic ov_t obs();
    obs = {ERR, BUSY, DONE, Rin, Rout, EXT, IMMout, Ain, Gin, Gout, FN, IMM};
  endfunction

  task automatic chk(input string tag, input ov_t got, input ov_t want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  // Reference sequence straight from the instruction table.
  task automatic push_instr(input logic [9:0] ins);
    ov_t a, b, c;
    logic [1:0] m, x, y;
    logic [3:0] f, ohx, ohy;
    m = ins[9:8]; x = ins[7:6]; y = ins[5:4]; f = ins[3:0];
    ohx = 4'b0001 << x; ohy = 4'b0001 << y;
    a = '0; b = '0; c = '0;
    a.busy = 1; b.busy = 1; c.busy = 1;
    c.gout = 1; c.rin = ohx; c.done = 1;
    b.gin = 1; b.fn = f; a.ain = 1;
    if (m == 2'b01 || (m == 2'b00 && f >= 4'd12)) begin
      a.ain = 0; a.done = 1; a.err = TRAP;
      q.push_back(a);
    end else if (m == 2'b00 && f == 4'd0) begin
      a.ain = 0; a.ext = 1; a.rin = ohx; a.done = 1;
      q.push_back(a);
    end else if (m == 2'b00 && f == 4'd1) begin
      a.ain = 0; a.rout = ohy; a.rin = ohx; a.done = 1;
      q.push_back(a);
    end else begin
      if (m == 2'b00 && (f == 4'd4 || f == 4'd5)) a.rout = ohy;
      else a.rout = ohx;
      if (m == 2'b00 && !(f == 4'd4 || f == 4'd5)) b.rout = ohy;
      if (m[1]) begin
        b.immout = 1; b.fn = (m == 2'b11) ? 4'b1101 : 4'b1100;
        a.imm = {4'b0, ins[5:0]}; b.imm = a.imm; c.imm = a.imm;
      end
      q.push_back(a); q.push_back(b); q.push_back(c);
    end
  endtask

  task automatic step(input string tag);
    ov_t want;
    @(negedge CLKb);
    @(posedge CLKb);
    #1;
    want = (q.size() > 0) ? q.pop_front() : ov_t'('0);
    chk(tag, obs(), want);
  endtask

  task automatic run_one(input logic [9:0] ins, input string tag);
    INSTR = ins; EXEC = 1'b1;
    push_instr(ins);
    q.push_back('0);
    step(tag);
    EXEC = 1'b0;
    while (q.size() > 0) step(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: run did not complete");
    $fatal(1);
  end

  initial begin
    RSTb = 1'b0; EXEC = 1'b1; INSTR = 10'b00_10_00_0000;
    @(posedge CLKb); #1;
    chk("rst_hold0", obs(), '0);
    @(posedge CLKb); #1;
    chk("rst_hold1", obs(), '0);
    RSTb = 1'b1;
    push_instr(10'b00_10_00_0000);
    step("rst_release_ld");
    EXEC = 1'b0;
    step("ld_idle");

    run_one(10'b00_01_11_0010, "add_r1_r3");
    run_one(10'b11_00_101101,  "subi_r0_45");
    run_one(10'b00_11_00_0001, "cp_r3_r0");
    run_one(10'b00_00_10_0100, "inv_r0_r2");
    run_one(10'b10_10_111111,  "addi_r2_63");
    run_one(10'b00_01_01_0010, "add_r1_r1");
    run_one(10'b00_10_01_1011, "fn1011_r2_r1");
    run_one(10'b01_00_000000,  "illegal_mode");
    run_one(10'b00_01_10_1110, "illegal_fn");

    // EXEC pulse while busy must not start another instruction
    INSTR = 10'b00_01_11_0010; EXEC = 1'b1;
    push_instr(INSTR); q.push_back('0);
    step("pulse_t1");
    EXEC = 1'b0;
    step("pulse_t2");
    INSTR = 10'b00_10_00_0000; EXEC = 1'b1;
    step("pulse_t3");
    EXEC = 1'b0;
    step("pulse_idle");

    // EXEC held: one IDLE cycle between DONE and the next accept
    INSTR = 10'b00_01_11_0010; EXEC = 1'b1;
    push_instr(10'b00_01_11_0010); q.push_back('0);
    push_instr(10'b00_11_00_0000); q.push_back('0);
    step("held_add_t1");
    INSTR = 10'b00_11_00_0000;
    step("held_add_t2");
    step("held_add_t3");
    step("held_gap");
    step("held_ld_t1");
    EXEC = 1'b0;
    step("held_final_idle");

    // Reset in T2 aborts with no DONE/Rin
    INSTR = 10'b00_01_11_0010; EXEC = 1'b1;
    push_instr(INSTR);
    step("abort_t1");
    EXEC = 1'b0;
    step("abort_t2");
    RSTb = 1'b0;
    #1;
    chk("abort_async", obs(), '0);
    q.delete();
    step("abort_hold");
    RSTb = 1'b1;
    step("abort_after");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
